// File: rtl/disp_mux_scan.sv
// N-channel display-source multiplexer with CPU shadow channel 0, manual select and timed auto-scan.
// Optional macro DISP_UPD_PULSE_EN adds a one-cycle 'upd' pulse after any displayed-value change.
module disp_mux_scan #(
  parameter int          NCH      = 8,
  parameter int          DW       = 32,
  parameter int          SEGW     = 8,
  parameter int          DWELL    = 50000000,
  parameter logic [31:0] RST_DATA = 32'hAA5555AA,
  localparam int         SELW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  EN,
  input  logic                  auto,
  input  logic [SELW-1:0]       sel,
  input  logic [NCH*DW-1:0]     data_flat,
  input  logic [NCH*SEGW-1:0]   les_flat,
  input  logic [NCH*SEGW-1:0]   point_flat,
  output logic [DW-1:0]         Disp_num,
  output logic [SEGW-1:0]       LE_out,
  output logic [SEGW-1:0]       point_out,
`ifdef DISP_UPD_PULSE_EN
  output logic                  upd,
`endif
  output logic [SELW-1:0]       ch_cur
);

  localparam int            CW     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] RST_D  = DW'(RST_DATA);
  localparam logic [CW-1:0] CNT_MX = CW'(DWELL - 1);
  localparam logic [SELW-1:0] CH_MX = SELW'(NCH - 1);

  logic [DW-1:0]   shadow_data_reg;
  logic [SEGW-1:0] shadow_les_reg;
  logic [SEGW-1:0] shadow_point_reg;
  logic [SELW-1:0] ch_cur_reg;
  logic [CW-1:0]   cnt_reg;
  logic [DW-1:0]   disp_reg;
  logic [SEGW-1:0] le_reg;
  logic [SEGW-1:0] point_reg;

  logic [DW-1:0]   ch_data  [NCH];
  logic [SEGW-1:0] ch_les   [NCH];
  logic [SEGW-1:0] ch_point [NCH];

  // Channel 0 is always served from the shadow, never from the live slice.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      if (gi == 0) begin : g_shadow
        assign ch_data[gi]  = shadow_data_reg;
        assign ch_les[gi]   = shadow_les_reg;
        assign ch_point[gi] = shadow_point_reg;
      end else begin : g_live
        assign ch_data[gi]  = data_flat[gi*DW +: DW];
        assign ch_les[gi]   = les_flat[gi*SEGW +: SEGW];
        assign ch_point[gi] = point_flat[gi*SEGW +: SEGW];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_data_reg  <= RST_D;
      shadow_les_reg   <= '1;
      shadow_point_reg <= '0;
    end else if (EN) begin
      shadow_data_reg  <= data_flat[DW-1:0];
      shadow_les_reg   <= les_flat[SEGW-1:0];
      shadow_point_reg <= point_flat[SEGW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_cur_reg <= '0;
      cnt_reg    <= '0;
    end else if (!auto) begin
      ch_cur_reg <= (32'(sel) >= NCH) ? '0 : sel;
      cnt_reg    <= '0;
    end else if (cnt_reg == CNT_MX) begin
      cnt_reg    <= '0;
      ch_cur_reg <= (ch_cur_reg == CH_MX) ? '0 : ch_cur_reg + 1'b1;
    end else begin
      cnt_reg    <= cnt_reg + 1'b1;
    end
  end

  // Outputs use the channel selected before this edge, giving the 2-cycle sel latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_reg  <= RST_D;
      le_reg    <= '1;
      point_reg <= '0;
    end else begin
      disp_reg  <= ch_data[ch_cur_reg];
      le_reg    <= ch_les[ch_cur_reg];
      point_reg <= ch_point[ch_cur_reg];
    end
  end

`ifdef DISP_UPD_PULSE_EN
  logic [DW+2*SEGW-1:0] prev_reg;
  logic                 upd_reg;

  // prev_reg lags the outputs by one edge, so the pulse lands one cycle after the change.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_reg <= {RST_D, {SEGW{1'b1}}, {SEGW{1'b0}}};
      upd_reg  <= 1'b0;
    end else begin
      prev_reg <= {disp_reg, le_reg, point_reg};
      upd_reg  <= ({disp_reg, le_reg, point_reg} != prev_reg);
    end
  end

  assign upd = upd_reg;
`endif

  assign Disp_num  = disp_reg;
  assign LE_out    = le_reg;
  assign point_out = point_reg;
  assign ch_cur    = ch_cur_reg;

endmodule

// File: tb/tb_disp_mux_scan.sv
// Directed bench for disp_mux_scan: one 8-channel instance (DWELL=3) and one 5-channel instance (DWELL=2).
module tb_disp_mux_scan;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: NCH=8, DWELL=3
  logic           a_en = 1'b0, a_auto = 1'b0;
  logic [2:0]     a_sel = '0;
  logic [255:0]   a_data = '0;
  logic [63:0]    a_les = '0, a_pt = '0;
  logic [31:0]    a_disp;
  logic [7:0]     a_le, a_pto;
  logic [2:0]     a_ch;
`ifdef DISP_UPD_PULSE_EN
  logic           a_upd, b_upd;
`endif

  // Instance B: NCH=5, DWELL=2
  logic           b_en = 1'b0, b_auto = 1'b0;
  logic [2:0]     b_sel = '0;
  logic [159:0]   b_data = '0;
  logic [39:0]    b_les = '0, b_pt = '0;
  logic [31:0]    b_disp;
  logic [7:0]     b_le, b_pto;
  logic [2:0]     b_ch;

  disp_mux_scan #(.NCH(8), .DW(32), .SEGW(8), .DWELL(3)) dut_a (
    .clk(clk), .rst(rst), .EN(a_en), .auto(a_auto), .sel(a_sel),
    .data_flat(a_data), .les_flat(a_les), .point_flat(a_pt),
    .Disp_num(a_disp), .LE_out(a_le), .point_out(a_pto),
`ifdef DISP_UPD_PULSE_EN
    .upd(a_upd),
`endif
    .ch_cur(a_ch)
  );

  disp_mux_scan #(.NCH(5), .DW(32), .SEGW(8), .DWELL(2)) dut_b (
    .clk(clk), .rst(rst), .EN(b_en), .auto(b_auto), .sel(b_sel),
    .data_flat(b_data), .les_flat(b_les), .point_flat(b_pt),
    .Disp_num(b_disp), .LE_out(b_le), .point_out(b_pto),
`ifdef DISP_UPD_PULSE_EN
    .upd(b_upd),
`endif
    .ch_cur(b_ch)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hand-entered auto-scan sequence for instance A starting at channel 6.
  logic [2:0] a_seq [10] = '{3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd1};
  logic [2:0] b_seq [11] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd0};

  function automatic logic [31:0] a_val(input logic [2:0] ch);
    return (ch == 3'd0) ? 32'h12345678 : (32'hC0DE0000 | 32'(ch));
  endfunction

  initial begin
    // Reset / default
    #12;
    check("rst_disp", a_disp, 32'hAA5555AA);
    check("rst_le",   a_le,   8'hFF);
    check("rst_pt",   a_pto,  8'h00);
    check("rst_ch",   a_ch,   3'd0);
`ifdef DISP_UPD_PULSE_EN
    check("rst_upd",  a_upd,  1'b0);
`endif
    step(1);
    rst = 1'b1;
    step(1);
    check("post_rst_disp", a_disp, 32'hAA5555AA);
    check("post_rst_le",   a_le,   8'hFF);
`ifdef DISP_UPD_PULSE_EN
    check("post_rst_upd",  a_upd,  1'b0);
`endif

    // Shadow capture
    a_data[31:0] = 32'h12345678; a_les[7:0] = 8'h0F; a_pt[7:0] = 8'h81; a_en = 1'b1;
    step(1);
    a_en = 1'b0; a_data[31:0] = 32'h0;
    check("cap_lat1_disp", a_disp, 32'hAA5555AA);
    step(1);
    check("cap_disp", a_disp, 32'h12345678);
    check("cap_le",   a_le,   8'h0F);
    check("cap_pt",   a_pto,  8'h81);
    step(1);
`ifdef DISP_UPD_PULSE_EN
    check("cap_upd_hi", a_upd, 1'b1);
`endif
    step(1);
    check("hold_disp", a_disp, 32'h12345678);
    check("hold_pt",   a_pto,  8'h81);
`ifdef DISP_UPD_PULSE_EN
    check("cap_upd_lo", a_upd, 1'b0);
`endif

    // Manual select
    a_sel = 3'd5; a_data[5*32 +: 32] = 32'hDEADBEEF; a_les[5*8 +: 8] = 8'hA5; a_pt[5*8 +: 8] = 8'h3C;
    step(1);
    check("man_ch", a_ch, 3'd5);
    check("man_lat1_disp", a_disp, 32'h12345678);
    step(1);
    check("man_disp", a_disp, 32'hDEADBEEF);
    check("man_le",   a_le,   8'hA5);
    check("man_pt",   a_pto,  8'h3C);
    a_data[5*32 +: 32] = 32'h1;
    step(1);
    check("live_disp", a_disp, 32'h1);

    // Auto-scan wrap from channel 6
    for (int k = 1; k < 8; k++) a_data[k*32 +: 32] = 32'hC0DE0000 | 32'(k);
    a_sel = 3'd6;
    step(1);
    check("pre_auto_ch", a_ch, 3'd6);
    a_auto = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(1);
      check($sformatf("auto_ch%0d", i), a_ch, a_seq[i+1]);
      check($sformatf("auto_disp%0d", i), a_disp, a_val(a_seq[i]));
    end

    // Reset mid-scan: now at ch 1, counter 0; advance to ch 4 counter 1
    step(10);
    check("mid_ch", a_ch, 3'd4);
    rst = 1'b0;
    #1;
    check("mid_rst_disp", a_disp, 32'hAA5555AA);
    check("mid_rst_le",   a_le,   8'hFF);
    check("mid_rst_ch",   a_ch,   3'd0);
    step(1);
    rst = 1'b1;
    step(1);
    check("rel_ch1", a_ch, 3'd0);
    check("rel_disp", a_disp, 32'hAA5555AA);
    step(1);
    check("rel_ch2", a_ch, 3'd0);
    step(1);
    check("rel_ch3", a_ch, 3'd1);

    // Non-power-of-two NCH and mode switching (instance B)
    for (int k = 1; k < 5; k++) b_data[k*32 +: 32] = 32'hB0000000 | 32'(k);
    b_sel = 3'd4;
    step(1);
    check("b_sel4", b_ch, 3'd4);
    b_sel = 3'd6;
    step(1);
    check("b_sel6", b_ch, 3'd0);
    b_sel = 3'd7;
    step(1);
    check("b_sel7", b_ch, 3'd0);
    b_auto = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check($sformatf("b_auto_ch%0d", i), b_ch, b_seq[i+1]);
    end
    step(3);
    check("b_pre_man", b_ch, 3'd1);
    b_auto = 1'b0; b_sel = 3'd3;
    step(1);
    check("b_man3", b_ch, 3'd3);
    b_auto = 1'b1;
    step(1);
    check("b_resume_ch", b_ch, 3'd3);
    check("b_resume_disp", b_disp, 32'hB0000003);
    step(1);
    check("b_adv_ch", b_ch, 3'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
